sv32_ptw: RTL and testbench
===========================

// Module: sv32_ptw
// PURPOSE
//  Sv32 hardware page-table walker; the producer side of the TLB fill interface.
//  - On a TLB miss, walks the two-level page table through a single-outstanding memory read port.
//  - Ends each walk with either a one-cycle TLB fill pulse or a one-cycle page-fault pulse.
//  - Sits between the MMU miss logic, the TLB fill port and the data-memory arbiter.
// PARAMETERS
//  ADDR_WIDTH   32  width of mem_addr_o; the 34-bit Sv32 PTE address is truncated to its low ADDR_WIDTH bits
//  CHECK_A_BIT  1   1: a leaf with A=0 faults (A/D managed in software); 0: A bit not checked
// PORTS
//  clk               input   1   clock, rising edge
//  rst_n             input   1   asynchronous active-low reset
//  satp_ppn_i        input   22  root page-table PPN (satp.PPN)
//  walk_req_i        input   1   miss request; accepted only when walk_ready_o=1
//  walk_vaddr_i      input   32  faulting virtual address
//  walk_ready_o      output  1   PTW idle, can accept a walk
//  mem_req_o         output  1   PTE read request, held high until mem_valid_i
//  mem_addr_o        output  ADDR_WIDTH  PTE address
//  mem_valid_i       input   1   read data valid; completes the current request
//  mem_rdata_i       input   32  PTE read data
//  fill_req_o        output  1   one-cycle TLB fill strobe
//  fill_vpn_o        output  20  vaddr[31:12] of the walk
//  fill_ppn_o        output  22  leaf PTE[31:10]
//  fill_perm_o       output  7   leaf PTE[7:1] = {D,A,G,U,X,W,R}
//  fill_superpage_o  output  1   leaf found at level 1 (4MB page)
//  fault_o           output  1   one-cycle page-fault strobe
//  fault_vaddr_o     output  32  latched walk vaddr; valid while fault_o=1
//  flush_i           input   1   SFENCE.VMA / satp write: abort the walk, no fill
// BEHAVIOUR
//  - States: IDLE, REQ, DRAIN, FILL, FAULT. Reset enters IDLE.
//  - Reset values: all outputs 0 except walk_ready_o=1; level=1; latched vaddr/base = 0.
//  - IDLE: walk_ready_o=1.
//    - If walk_req_i=1 and flush_i=0: latch walk_vaddr_i, base=satp_ppn_i, level=1; go to REQ.
//  - REQ: mem_req_o=1.
//    - mem_addr_o = {base, vpn[level], 2'b00}[ADDR_WIDTH-1:0], where vpn1=va[31:22] and vpn0=va[21:12].
//    - While mem_valid_i=0, stay in REQ with mem_addr_o unchanged.
//  - PTE decode in REQ when mem_valid_i=1 (pte = mem_rdata_i). Rules in priority order:
//    1. V=0, or (R=0 and W=1) -> FAULT.
//    2. R|X=1 (leaf):
//       - level=1 and pte[19:10]!=0 (misaligned superpage) -> FAULT.
//       - CHECK_A_BIT=1 and A=0 -> FAULT.
//       - otherwise -> FILL.
//    3. Pointer (R=X=0):
//       - level=0 -> FAULT.
//       - level=1 -> base=pte[31:10], level=0, stay in REQ. mem_req_o stays high next cycle with the new address (back-to-back request).
//  - FILL: fill_req_o=1 for exactly one cycle.
//    - fill_vpn_o = va[31:22] ++ va[21:12] (i.e. va[31:12]); fill_ppn_o = pte[31:10]; fill_perm_o = pte[7:1]; fill_superpage_o = (level==1).
//    - Next state: IDLE.
//  - FAULT: fault_o=1 for exactly one cycle, fault_vaddr_o = latched vaddr; next state: IDLE.
//  - fill_* and fault_vaddr_o data are 0 whenever their strobe is low.
//  - Latency, zero-wait memory (mem_valid_i in the first REQ cycle); request accepted in cycle 0:
//    - megapage: fill at cycle 2.
//    - 4KB page: fill at cycle 3.
//  - flush_i (any state):
//    - IDLE: blocks acceptance of walk_req_i in that cycle.
//    - REQ: the outstanding read cannot be cancelled. With mem_valid_i=0 go to DRAIN; with mem_valid_i=1 in the same cycle go directly to IDLE.
//    - DRAIN: mem_req_o=0, walk_ready_o=0; wait for mem_valid_i, discard the data, go to IDLE.
//    - FILL/FAULT: suppresses fill_req_o/fault_o in that cycle; go to IDLE.
//  - Ignored inputs: walk_req_i outside IDLE; mem_valid_i in IDLE, FILL and FAULT.
//  - Reset asserted mid-walk: immediate return to IDLE, strobes drop asynchronously. The memory side must also be reset.
// TESTING
//  1. Megapage, satp_ppn=22'h00080, vaddr=32'h4000_1234.
//     -> mem_addr_o=32'h0008_0400.
//     PTE=32'h2000_00CF -> fill_req_o pulse with vpn=20'h40001, ppn=22'h080000, perm=7'h67, superpage=1, at cycle 2.
//  2. 4KB page, same vaddr. L1 PTE=32'h0002_0401 -> second read at 32'h0008_1004.
//     L0 PTE=32'h048D_14C3 -> ppn=22'h012345, perm=7'h61, superpage=0, at cycle 3.
//  3. Faults, each giving fault_o=1 with fault_vaddr_o=32'h4000_1234 and no fill_req_o:
//     - L1 PTE=32'h2000_04CF (misaligned superpage) -> fault.
//     - L1 PTE=0 (V=0) -> fault.
//     - L0 PTE=32'h0002_0401 (pointer at level 0) -> fault.
//     - W-only PTE=32'h0000_0005 -> fault.
//  4. CHECK_A_BIT=1, leaf PTE=32'h2000_008F (A=0) -> fault.
//     Same PTE with CHECK_A_BIT=0 -> fill with perm=7'h47.
//  5. flush_i during a 5-cycle memory wait -> DRAIN; walk_ready_o returns to 1 one cycle after mem_valid_i; no fill_req_o or fault_o.
//     walk_req_i pulsed while busy -> ignored.
//  6. rst_n low while in REQ -> walk_ready_o=1 and mem_req_o=0 immediately.
//     After release, a new walk completes normally.

Source files
------------

// File: rtl/sv32_ptw.sv
// sv32_ptw: Sv32 two-level hardware page-table walker producing TLB fills or page faults
module sv32_ptw #(
   parameter int ADDR_WIDTH  = 32,
   parameter bit CHECK_A_BIT = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [21:0]           satp_ppn_i,
   input  logic                  walk_req_i,
   input  logic [31:0]           walk_vaddr_i,
   output logic                  walk_ready_o,
   output logic                  mem_req_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   input  logic                  mem_valid_i,
   input  logic [31:0]           mem_rdata_i,
   output logic                  fill_req_o,
   output logic [19:0]           fill_vpn_o,
   output logic [21:0]           fill_ppn_o,
   output logic [6:0]            fill_perm_o,
   output logic                  fill_superpage_o,
   output logic                  fault_o,
   output logic [31:0]           fault_vaddr_o,
   input  logic                  flush_i
);
   typedef enum logic [2:0] {IDLE, REQ, DRAIN, FILL, FAULT} state_t;
   state_t state;
   logic level;
   logic [31:0] vaddr;
   logic [21:0] base;
   logic [21:0] leaf_ppn;
   logic [6:0] leaf_perm;
   logic leaf;
   logic bad;
   logic unused_rsw;
   // PTE address is 34 bits in Sv32; narrower memory buses keep only the low bits
   function automatic logic [ADDR_WIDTH-1:0] pte_addr(input logic [21:0] b, input logic [9:0] idx);
      logic [33:0] full;
      full = {b, idx, 2'b00};
      return full[ADDR_WIDTH-1:0];
   endfunction
   assign unused_rsw = ^mem_rdata_i[9:8];
   assign walk_ready_o = state == IDLE;
   assign mem_req_o = state == REQ;
   assign mem_addr_o = pte_addr(base, level ? vaddr[31:22] : vaddr[21:12]);
   // a flush in the strobe cycle cancels the strobe, so strobes are gated combinationally
   assign fill_req_o = state == FILL && !flush_i;
   assign fill_vpn_o = fill_req_o ? vaddr[31:12] : '0;
   assign fill_ppn_o = fill_req_o ? leaf_ppn : '0;
   assign fill_perm_o = fill_req_o ? leaf_perm : '0;
   assign fill_superpage_o = fill_req_o && level;
   assign fault_o = state == FAULT && !flush_i;
   assign fault_vaddr_o = fault_o ? vaddr : '0;
   // classify the returned PTE: leaf or pointer, and whether it faults at this level
   always_comb begin
      leaf = mem_rdata_i[1] | mem_rdata_i[3];
      bad = !mem_rdata_i[0] || (!mem_rdata_i[1] && mem_rdata_i[2]) ||
            (leaf ? ((level && mem_rdata_i[19:10] != '0) || (CHECK_A_BIT && !mem_rdata_i[6])) : !level);
   end
   // walk sequencing: accept, read one PTE per level, end in a fill or fault strobe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         level <= 1'b1;
         vaddr <= '0;
         base <= '0;
         leaf_ppn <= '0;
         leaf_perm <= '0;
      end else begin
         case (state)
            IDLE: if (walk_req_i && !flush_i) begin
               vaddr <= walk_vaddr_i;
               base <= satp_ppn_i;
               level <= 1'b1;
               state <= REQ;
            end
            REQ: if (flush_i) begin
               state <= mem_valid_i ? IDLE : DRAIN;
            end else if (mem_valid_i) begin
               if (bad) begin
                  state <= FAULT;
               end else if (leaf) begin
                  state <= FILL;
                  leaf_ppn <= mem_rdata_i[31:10];
                  leaf_perm <= mem_rdata_i[7:1];
               end else begin
                  base <= mem_rdata_i[31:10];
                  level <= 1'b0;
               end
            end
            DRAIN: if (mem_valid_i) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sv32_ptw.sv
// tb_sv32_ptw: scoreboard bench for the Sv32 page-table walker
module tb_sv32_ptw;
   logic clk = 0, rst_n = 0;
   logic [21:0] satp_ppn_i = 22'h00080;
   logic walk_req_i = 0, mem_valid_i = 0, flush_i = 0;
   logic [31:0] walk_vaddr_i = 0, mem_rdata_i = 0;
   logic walk_ready_o, mem_req_o, fill_req_o, fill_superpage_o, fault_o;
   logic [31:0] mem_addr_o, fault_vaddr_o;
   logic [19:0] fill_vpn_o;
   logic [21:0] fill_ppn_o;
   logic [6:0] fill_perm_o;
   logic ready_b, mreq_b, fill_b, sp_b, fault_b;
   logic [31:0] addr_b, fva_b;
   logic [19:0] vpn_b;
   logic [21:0] ppn_b;
   logic [6:0] perm_b;
   int cyc = 0;
   int vectors = 0, miscompares = 0;
   typedef struct {
      bit is_fill;
      logic [19:0] vpn;
      logic [21:0] ppn;
      logic [6:0] perm;
      logic sp;
      logic [31:0] va;
      int cyc;
   } exp_t;
   exp_t exp_q[$];
   exp_t e;
   localparam logic [31:0] VA = 32'h4000_1234;
   localparam logic [31:0] FL1 [4] = '{32'h2000_04CF, 32'h0, 32'h0002_0401, 32'h0000_0005};
   localparam bit FTWO [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

   sv32_ptw #(.ADDR_WIDTH(32), .CHECK_A_BIT(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .satp_ppn_i(satp_ppn_i), .walk_req_i(walk_req_i),
      .walk_vaddr_i(walk_vaddr_i), .walk_ready_o(walk_ready_o), .mem_req_o(mem_req_o),
      .mem_addr_o(mem_addr_o), .mem_valid_i(mem_valid_i), .mem_rdata_i(mem_rdata_i),
      .fill_req_o(fill_req_o), .fill_vpn_o(fill_vpn_o), .fill_ppn_o(fill_ppn_o),
      .fill_perm_o(fill_perm_o), .fill_superpage_o(fill_superpage_o), .fault_o(fault_o),
      .fault_vaddr_o(fault_vaddr_o), .flush_i(flush_i));

   sv32_ptw #(.ADDR_WIDTH(32), .CHECK_A_BIT(1'b0)) dut_b (
      .clk(clk), .rst_n(rst_n), .satp_ppn_i(satp_ppn_i), .walk_req_i(walk_req_i),
      .walk_vaddr_i(walk_vaddr_i), .walk_ready_o(ready_b), .mem_req_o(mreq_b),
      .mem_addr_o(addr_b), .mem_valid_i(mem_valid_i), .mem_rdata_i(mem_rdata_i),
      .fill_req_o(fill_b), .fill_vpn_o(vpn_b), .fill_ppn_o(ppn_b),
      .fill_perm_o(perm_b), .fill_superpage_o(sp_b), .fault_o(fault_b),
      .fault_vaddr_o(fva_b), .flush_i(flush_i));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL global_timeout cycle=%0d", cyc);
      $fatal(1, "timeout");
   end

   // monitor: every strobe pops one expected event; idle fill data must read zero
   always @(negedge clk) if (rst_n) begin
      vectors++;
      if (!fill_req_o && {fill_vpn_o, fill_ppn_o, fill_perm_o, fill_superpage_o} !== '0) begin
         miscompares++;
         $display("FAIL idle_fill_data got %h required 0", {fill_vpn_o, fill_ppn_o, fill_perm_o, fill_superpage_o});
      end
      if (fill_req_o || fault_o) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_strobe got fill=%b fault=%b required none at cycle %0d", fill_req_o, fault_o, cyc);
         end else begin
            e = exp_q.pop_front();
            if (fill_req_o !== e.is_fill || fault_o !== !e.is_fill) begin
               miscompares++;
               $display("FAIL strobe_kind got fill=%b fault=%b required fill=%b", fill_req_o, fault_o, e.is_fill);
            end else if (e.is_fill && {fill_vpn_o, fill_ppn_o, fill_perm_o, fill_superpage_o} !== {e.vpn, e.ppn, e.perm, e.sp}) begin
               miscompares++;
               $display("FAIL fill_data got vpn=%h ppn=%h perm=%h sp=%b required vpn=%h ppn=%h perm=%h sp=%b",
                        fill_vpn_o, fill_ppn_o, fill_perm_o, fill_superpage_o, e.vpn, e.ppn, e.perm, e.sp);
            end else if (!e.is_fill && fault_vaddr_o !== e.va) begin
               miscompares++;
               $display("FAIL fault_vaddr got %h required %h", fault_vaddr_o, e.va);
            end
            vectors++;
            if (e.cyc >= 0 && cyc !== e.cyc) begin
               miscompares++;
               $display("FAIL strobe_latency got cycle %0d required %0d", cyc, e.cyc);
            end
         end
      end
   end

   function automatic void push_fill(input logic [19:0] vpn, input logic [21:0] ppn, input logic [6:0] perm, input logic sp, input int c);
      exp_t x;
      x.is_fill = 1; x.vpn = vpn; x.ppn = ppn; x.perm = perm; x.sp = sp; x.va = 0; x.cyc = c;
      exp_q.push_back(x);
   endfunction

   function automatic void push_fault(input logic [31:0] va, input int c);
      exp_t x;
      x.is_fill = 0; x.vpn = 0; x.ppn = 0; x.perm = 0; x.sp = 0; x.va = va; x.cyc = c;
      exp_q.push_back(x);
   endfunction

   task automatic start(input logic [31:0] va, output int c0);
      walk_req_i = 1; walk_vaddr_i = va; c0 = cyc;
      @(posedge clk); #1;
      walk_req_i = 0;
   endtask

   // wait (bounded) for a read request, note its address, answer after 'waits' cycles
   task automatic serve(input logic [31:0] pte, input int waits, output logic [31:0] addr, output bit ok);
      int n = 0;
      ok = 1; addr = 'x;
      while (!mem_req_o && n < 20) begin @(posedge clk); #1; n++; end
      if (!mem_req_o) begin ok = 0; return; end
      addr = mem_addr_o;
      repeat (waits) begin @(posedge clk); #1; end
      mem_valid_i = 1; mem_rdata_i = pte;
      @(posedge clk); #1;
      mem_valid_i = 0; mem_rdata_i = 0;
   endtask

   task automatic settle();
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if ({walk_ready_o, mem_req_o, fill_req_o, fault_o, mem_addr_o, fault_vaddr_o, ready_b} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1}) begin
         miscompares++;
         $display("FAIL reset_state got rdy=%b req=%b fill=%b flt=%b addr=%h fva=%h rdy_b=%b required rdy=1 others 0",
                  walk_ready_o, mem_req_o, fill_req_o, fault_o, mem_addr_o, fault_vaddr_o, ready_b);
      end
      rst_n = 1;
      @(posedge clk); #1;
   endtask

   task automatic test_megapage();
      int c0; logic [31:0] a; bit ok;
      start(VA, c0);
      push_fill(20'h40001, 22'h080000, 7'h67, 1'b1, c0 + 2);
      serve(32'h2000_00CF, 0, a, ok);
      vectors++;
      if (!ok || a !== 32'h0008_0400) begin
         miscompares++;
         $display("FAIL mega_addr got %h ok=%0d required 00080400", a, ok);
      end
      settle();
   endtask

   task automatic test_4k_page();
      int c0; logic [31:0] a1, a2; bit ok1, ok2;
      start(VA, c0);
      push_fill(20'h40001, 22'h012345, 7'h61, 1'b0, c0 + 3);
      serve(32'h0002_0401, 0, a1, ok1);
      serve(32'h048D_14C3, 0, a2, ok2);
      vectors++;
      if (!ok1 || a1 !== 32'h0008_0400) begin
         miscompares++;
         $display("FAIL l1_addr got %h ok=%0d required 00080400", a1, ok1);
      end
      vectors++;
      if (!ok2 || a2 !== 32'h0008_1004) begin
         miscompares++;
         $display("FAIL l0_addr got %h ok=%0d required 00081004", a2, ok2);
      end
      settle();
   endtask

   task automatic test_faults();
      int c0; logic [31:0] a; bit ok;
      for (int i = 0; i < 4; i++) begin
         start(VA, c0);
         push_fault(VA, FTWO[i] ? c0 + 3 : c0 + 2);
         serve(FL1[i], 0, a, ok);
         if (FTWO[i]) serve(32'h0002_0401, 0, a, ok);
         vectors++;
         if (!ok) begin
            miscompares++;
            $display("FAIL fault_case%0d_req got no mem_req_o required a read", i);
         end
         settle();
      end
   endtask

   task automatic test_a_bit();
      int c0; logic [31:0] a; bit ok;
      start(VA, c0);
      push_fault(VA, c0 + 2);
      serve(32'h2000_008F, 0, a, ok);
      vectors++;
      if (!ok || {fill_b, fault_b, ppn_b, perm_b, sp_b} !== {1'b1, 1'b0, 22'h080000, 7'h47, 1'b1}) begin
         miscompares++;
         $display("FAIL no_a_check_fill got fill=%b flt=%b ppn=%h perm=%h sp=%b required fill=1 flt=0 ppn=080000 perm=47 sp=1",
                  fill_b, fault_b, ppn_b, perm_b, sp_b);
      end
      settle();
   endtask

   task automatic test_flush();
      int c0; logic [31:0] a; bit ok;
      // flush while the read is outstanding: drain, ignore a busy request, then idle
      start(VA, c0);
      flush_i = 1;
      @(posedge clk); #1;
      flush_i = 0;
      walk_req_i = 1; walk_vaddr_i = 32'h8000_0000;
      vectors++;
      if ({mem_req_o, walk_ready_o} !== 2'b00) begin
         miscompares++;
         $display("FAIL drain_state got req=%b rdy=%b required req=0 rdy=0", mem_req_o, walk_ready_o);
      end
      @(posedge clk); #1;
      walk_req_i = 0;
      repeat (2) begin @(posedge clk); #1; end
      vectors++;
      if (walk_ready_o !== 1'b0) begin
         miscompares++;
         $display("FAIL drain_hold got rdy=%b required 0", walk_ready_o);
      end
      mem_valid_i = 1; mem_rdata_i = 32'h2000_00CF;
      @(posedge clk); #1;
      mem_valid_i = 0; mem_rdata_i = 0;
      vectors++;
      if ({walk_ready_o, mem_req_o} !== 2'b10) begin
         miscompares++;
         $display("FAIL drain_exit got rdy=%b req=%b required rdy=1 req=0", walk_ready_o, mem_req_o);
      end
      @(posedge clk); #1;
      vectors++;
      if ({walk_ready_o, mem_req_o} !== 2'b10) begin
         miscompares++;
         $display("FAIL busy_req_ignored got rdy=%b req=%b required rdy=1 req=0", walk_ready_o, mem_req_o);
      end
      // flush together with read data: straight back to idle
      start(VA, c0);
      flush_i = 1; mem_valid_i = 1; mem_rdata_i = 32'h2000_00CF;
      @(posedge clk); #1;
      flush_i = 0; mem_valid_i = 0; mem_rdata_i = 0;
      vectors++;
      if (walk_ready_o !== 1'b1) begin
         miscompares++;
         $display("FAIL flush_with_valid got rdy=%b required 1", walk_ready_o);
      end
      // flush in the fill cycle suppresses the strobe
      start(VA, c0);
      serve(32'h2000_00CF, 0, a, ok);
      flush_i = 1;
      #1;
      vectors++;
      if (!ok || {fill_req_o, fill_vpn_o, fill_b} !== '0) begin
         miscompares++;
         $display("FAIL flush_in_fill got fill=%b vpn=%h fill_b=%b ok=%0d required 0", fill_req_o, fill_vpn_o, fill_b, ok);
      end
      @(posedge clk); #1;
      flush_i = 0;
      vectors++;
      if (walk_ready_o !== 1'b1) begin
         miscompares++;
         $display("FAIL flush_fill_exit got rdy=%b required 1", walk_ready_o);
      end
      // flush in idle blocks acceptance
      walk_req_i = 1; walk_vaddr_i = VA; flush_i = 1;
      @(posedge clk); #1;
      walk_req_i = 0; flush_i = 0;
      vectors++;
      if ({walk_ready_o, mem_req_o} !== 2'b10) begin
         miscompares++;
         $display("FAIL flush_idle got rdy=%b req=%b required rdy=1 req=0", walk_ready_o, mem_req_o);
      end
      settle();
   endtask

   task automatic test_reset_mid_walk();
      int c0; logic [31:0] a; bit ok;
      start(VA, c0);
      rst_n = 0;
      #1;
      vectors++;
      if ({walk_ready_o, mem_req_o} !== 2'b10) begin
         miscompares++;
         $display("FAIL async_reset got rdy=%b req=%b required rdy=1 req=0", walk_ready_o, mem_req_o);
      end
      @(posedge clk); #1;
      rst_n = 1;
      @(posedge clk); #1;
      start(32'hC040_3000, c0);
      push_fill(20'hC0403, 22'h080000, 7'h67, 1'b1, c0 + 2);
      serve(32'h2000_00CF, 0, a, ok);
      vectors++;
      if (!ok || a !== 32'h0008_0C04) begin
         miscompares++;
         $display("FAIL post_reset_addr got %h ok=%0d required 00080C04", a, ok);
      end
      settle();
   endtask

   initial begin
      test_reset();
      test_megapage();
      test_4k_page();
      test_faults();
      test_a_bit();
      test_flush();
      test_reset_mid_walk();
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL missing_strobes got %0d pending required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
